i2c_bit_ctrl: RTL
=================

Name: i2c_bit_ctrl

Overview:
- I2C bit-level engine for the AT24C256 EEPROM path.
- Sits directly downstream of the prescaler. It consumes the prescaler's 1-cycle tick; each tick equals one quarter SCL period.
- Executes one bus primitive per command (START, STOP, WRITE bit, READ bit) and drives open-drain SCL/SDA enables.
- The byte/transaction controller above it issues commands over a valid/ready handshake.

Parameters:
- STRETCH_EN, 1, 1 = honour slave clock stretching (wait for scl_i high before leaving the first SCL-high quarter); 0 = ignore scl_i.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  quarter-period strobe from prescaler, 1 clk wide
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle and able to accept a command
- cmd  in  3  1=START, 2=STOP, 3=WRITE, 4=READ; other codes illegal
- cmd_din  in  1  bit to send for WRITE, captured at acceptance
- done  out  1  1-clk pulse when the command completes
- dout  out  1  bit sampled by READ, valid from done until the next READ done
- busy  out  1  high from acceptance until done
- scl_i  in  1  SCL pin level (synchronised externally)
- sda_i  in  1  SDA pin level (synchronised externally)
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release

Behaviour:
- All outputs are registered. Reset values: scl_oe=0, sda_oe=0 (bus released), cmd_ready=1, busy=0, done=0, dout=0; FSM=IDLE; phase=Q0.
- FSM states: IDLE, START, STOP, WRITE, READ. Each non-IDLE state has phase counter Q0..Q3.
- Accept: cmd_valid && cmd_ready in IDLE.
  - Next edge: cmd_ready=0, busy=1, state=decoded cmd, phase=Q0.
  - cmd_din latched at the same edge.
- Phase advance: Q0->Q1->Q2 and Q2->Q3 on tick. Q3 ends on the next tick.
- Q1->Q2 requires tick && (scl_i || !STRETCH_EN). A tick with scl_i=0 is ignored; stay in Q1.
- A tick present in the same cycle as acceptance is ignored.
- Line levels per phase, written as (SDA released?, SCL released?), 1=released:
  - START: Q0 (1,1), Q1 (1,1), Q2 (0,1), Q3 (0,0).
  - STOP: Q0 (0,0), Q1 (0,1), Q2 (0,1), Q3 (1,1).
  - WRITE: SDA=cmd_din for all quarters; SCL Q0=0, Q1=1, Q2=1, Q3=0.
  - READ: SDA released for all quarters; SCL as WRITE.
    - dout <= sda_i on the Q1->Q2 advancing edge (middle of SCL high).
- Completion: the tick ending Q3 produces, at the same edge: done=1 for 1 clk, busy=0, cmd_ready=1, state=IDLE.
  - scl_oe/sda_oe hold the Q3 values while IDLE (bus state persists between commands).
- Back-to-back: a new command may be accepted in the first IDLE cycle, so minimum command spacing is 1 idle clk.
- Illegal cmd codes: accepted; no bus change; done pulses on the next clk; busy high for that one clk.
- cmd and cmd_din are don't-care when not accepted. cmd_valid while busy is ignored; the requester holds it.
- dout changes only on READ sampling.
- tick stuck high: advances one phase per clk (legal; 4-clk command).
- tick never arrives: engine stays in its phase indefinitely. No timeout in this block.
- Reset asserted mid-command: immediately scl_oe=0, sda_oe=0, FSM IDLE, no done pulse. The owner issues STOP after reset if required.

Test Plan:
- Tick every 5 clk; START from reset.
  - Expect sda_oe 0->1 at Q2 while scl_oe=0.
  - Expect scl_oe=1 at Q3.
  - Expect done 20 clk after acceptance+1; busy high throughout.
- WRITE cmd_din=1 then WRITE cmd_din=0 back-to-back.
  - sda_oe=0 then 1, each stable for all 4 quarters.
  - scl_oe pattern 1,0,0,1 per bit.
  - Two done pulses; cmd_ready high exactly 1 clk between them.
- READ with slave driving sda_i=0, then READ with sda_i=1 → dout=0 after first done, dout=1 after second; sda_oe=0 throughout both.
- Clock stretching (STRETCH_EN=1): hold scl_i=0 for 3 ticks after Q1 entry during WRITE → phase stays Q1, done delayed by exactly 3 tick periods. STRETCH_EN=0 → no delay.
- STOP after WRITE → sda_oe=1 with scl low, then SCL released, then SDA released in Q3. Final idle state: scl_oe=0, sda_oe=0.
- cmd=7 → done 1 clk after acceptance, bus unchanged. Assert rst_n low during READ Q2 → scl_oe=sda_oe=0 asynchronously, no done, cmd_ready=1 after release.

Source files
------------

// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level engine: runs one START/STOP/WRITE/READ primitive per accepted command,
// one quarter SCL period per prescaler tick, driving open-drain SCL/SDA enables.
module i2c_bit_ctrl #(
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic       cmd_din,
    output logic       done,
    output logic       dout,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    typedef enum logic [2:0] {StIdle, StStart, StStop, StWrite, StRead} state_e;
    typedef enum logic [1:0] {PhQ0, PhQ1, PhQ2, PhQ3} phase_e;

    state_e state_q;
    state_e cmd_state;
    phase_e phase_q;
    phase_e phase_nxt;
    logic   din_q;
    logic   advance;

    // Returns {sda_oe, scl_oe} for a primitive in a given quarter.
    function automatic logic [1:0] line_oe(state_e st, phase_e ph, logic din);
        logic scl_low;
        scl_low = (ph == PhQ0) || (ph == PhQ3);
        case (st)
            StStart: line_oe = {(ph == PhQ2) || (ph == PhQ3), ph == PhQ3};
            StStop:  line_oe = {ph != PhQ3, ph == PhQ0};
            StWrite: line_oe = {~din, scl_low};
            StRead:  line_oe = {1'b0, scl_low};
            default: line_oe = 2'b00;
        endcase
    endfunction

    always_comb begin
        cmd_state = StIdle;
        case (cmd)
            3'd1:    cmd_state = StStart;
            3'd2:    cmd_state = StStop;
            3'd3:    cmd_state = StWrite;
            3'd4:    cmd_state = StRead;
            default: cmd_state = StIdle;
        endcase
    end

    // A slave holding SCL low stalls the first SCL-high quarter.
    assign advance   = tick && ((phase_q != PhQ1) || scl_i || !STRETCH_EN);
    assign phase_nxt = phase_e'(phase_q + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            phase_q   <= PhQ0;
            din_q     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    // busy while idle marks an accepted illegal code awaiting its done.
                    if (busy) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        din_q     <= cmd_din;
                        phase_q   <= PhQ0;
                        state_q   <= cmd_state;
                        if (cmd_state != StIdle) begin
                            {sda_oe, scl_oe} <= line_oe(cmd_state, PhQ0, cmd_din);
                        end
                    end
                end
                default: begin
                    if (advance) begin
                        if (phase_q == PhQ3) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state_q   <= StIdle;
                            phase_q   <= PhQ0;
                        end else begin
                            phase_q          <= phase_nxt;
                            {sda_oe, scl_oe} <= line_oe(state_q, phase_nxt, din_q);
                            if (state_q == StRead && phase_q == PhQ1) begin
                                dout <= sda_i;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
